// File: rtl/flash_op_sequencer.sv
// Turns READ/PROGRAM/ERASE requests into nano4k_spi_flash controller command sequences.
// Optional build macro FLASH_SEQ_WEL_CHECK_EN: verify WEL via RDSR after WREN before PP/PE.
module flash_op_sequencer #(
    parameter int ADDR_W   = 22,
    parameter int LEN_W    = 9,
    parameter int GAP_CYC  = 4,
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 4096
) (
    input  logic              s_clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [7:0]        wr_data,
    output logic              wr_pop,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              error,
    output logic              ctl_enable_n,
    output logic [7:0]        ctl_cmd,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [7:0]        ctl_wdata,
    input  logic [7:0]        ctl_rdata,
    input  logic              ctl_rd_valid,
    input  logic              ctl_wr_ready,
    input  logic              ctl_cmd_finished
);

    localparam logic [7:0] OPC_WREN  = 8'h06;
    localparam logic [7:0] OPC_RDSR  = 8'h05;
    localparam logic [7:0] OPC_PP    = 8'h02;
    localparam logic [7:0] OPC_FREAD = 8'h0B;
    localparam logic [7:0] OPC_PE    = 8'h81;

    localparam int WAIT_MAX = (GAP_CYC > POLL_GAP) ? GAP_CYC : POLL_GAP;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int POLL_W   = $clog2(POLL_MAX + 1);
    localparam logic [LEN_W:0] LEN_LIMIT = (LEN_W + 1)'(256);

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_GAP, S_XFER, S_POLL, S_POLL_WAIT, S_FIN
    } state_e;

    typedef enum logic [1:0] {
        OP_READ = 2'b00, OP_PROG = 2'b01, OP_ERASE = 2'b10, OP_RSVD = 2'b11
    } op_e;

    // Where GAP hands over once the enable-high interval has elapsed
    typedef enum logic [1:0] { T_XFER, T_POLL, T_WEL, T_FIN } tgt_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    tgt_e                tgt_q, tgt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic                err_q, err_d;
    logic                wel_q, wel_d;
    logic                en_n_q, en_n_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   caddr_q, caddr_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                wr_pop_c;
    logic                req_bad;

    always_comb begin
        req_bad = 1'b0;
        if (op_e'(req_op) == OP_RSVD) begin
            req_bad = 1'b1;
        end else if (op_e'(req_op) != OP_ERASE) begin
            req_bad = (req_len == '0) || ({1'b0, req_len} > LEN_LIMIT);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tgt_d    = tgt_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        poll_d   = poll_q;
        err_d    = err_q;
        wel_d    = wel_q;
        en_n_d   = en_n_q;
        cmd_d    = cmd_q;
        caddr_d  = caddr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wr_pop_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    len_d   = req_len;
                    caddr_d = req_addr;
                    cnt_d   = '0;
                    poll_d  = '0;
                    err_d   = 1'b0;
                    wel_d   = 1'b0;
                    if (req_bad) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else if (op_e'(req_op) == OP_READ) begin
                        state_d = S_XFER;
                        cmd_d   = OPC_FREAD;
                        en_n_d  = 1'b0;
                    end else begin
                        state_d = S_WREN;
                        cmd_d   = OPC_WREN;
                        en_n_d  = 1'b0;
                    end
                end
            end

            S_WREN: begin
                if (ctl_cmd_finished) begin
                    en_n_d  = 1'b1;
                    state_d = S_GAP;
                    wait_d  = '0;
`ifdef FLASH_SEQ_WEL_CHECK_EN
                    tgt_d   = T_WEL;
`else
                    tgt_d   = T_XFER;
`endif
                end
            end

            S_GAP: begin
                if (wait_q == WAIT_W'(GAP_CYC - 1)) begin
                    case (tgt_q)
                        T_XFER: begin
                            state_d = S_XFER;
                            cmd_d   = (op_q == OP_PROG) ? OPC_PP : OPC_PE;
                            en_n_d  = 1'b0;
                            cnt_d   = '0;
                        end
                        T_POLL, T_WEL: begin
                            state_d = S_POLL;
                            cmd_d   = OPC_RDSR;
                            en_n_d  = 1'b0;
                            poll_d  = poll_q + POLL_W'(1);
                            wel_d   = (tgt_q == T_WEL);
                        end
                        default: state_d = S_FIN;
                    endcase
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_XFER: begin
                if (op_q == OP_READ) begin
                    if (ctl_rd_valid) begin
                        rdata_d  = ctl_rdata;
                        rvalid_d = 1'b1;
                        cnt_d    = cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            en_n_d  = 1'b1;
                            state_d = S_GAP;
                            wait_d  = '0;
                            tgt_d   = T_FIN;
                        end
                    end
                end else if (op_q == OP_PROG) begin
                    wr_pop_c = ctl_wr_ready;
                    if (ctl_wr_ready) begin
                        cnt_d = cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            en_n_d  = 1'b1;
                            state_d = S_GAP;
                            wait_d  = '0;
                            tgt_d   = T_POLL;
                        end
                    end
                end else if (ctl_cmd_finished) begin
                    en_n_d  = 1'b1;
                    state_d = S_GAP;
                    wait_d  = '0;
                    tgt_d   = T_POLL;
                end
            end

            S_POLL: begin
                // Only the first status byte matters; the RDSR is closed right after it
                if (ctl_rd_valid) begin
                    en_n_d = 1'b1;
                    wait_d = '0;
                    if (wel_q) begin
                        wel_d  = 1'b0;
                        poll_d = '0;
                        if (ctl_rdata[1]) begin
                            state_d = S_GAP;
                            tgt_d   = T_XFER;
                        end else begin
                            state_d = S_FIN;
                            err_d   = 1'b1;
                        end
                    end else if (!ctl_rdata[0]) begin
                        state_d = S_FIN;
                    end else if (poll_q == POLL_W'(POLL_MAX)) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_POLL_WAIT;
                    end
                end
            end

            S_POLL_WAIT: begin
                if (wait_q == WAIT_W'(POLL_GAP - 1)) begin
                    state_d = S_POLL;
                    cmd_d   = OPC_RDSR;
                    en_n_d  = 1'b0;
                    poll_d  = poll_q + POLL_W'(1);
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s_clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_READ;
            tgt_q    <= T_FIN;
            len_q    <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            poll_q   <= '0;
            err_q    <= 1'b0;
            wel_q    <= 1'b0;
            en_n_q   <= 1'b1;
            cmd_q    <= '0;
            caddr_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tgt_q    <= tgt_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            poll_q   <= poll_d;
            err_q    <= err_d;
            wel_q    <= wel_d;
            en_n_q   <= en_n_d;
            cmd_q    <= cmd_d;
            caddr_q  <= caddr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Combinational outputs are masked during reset so the reset cycle is quiet
    assign req_ready    = (state_q == S_IDLE) && !reset;
    assign done         = (state_q == S_FIN) && !reset;
    assign error        = done && err_q;
    assign wr_pop       = wr_pop_c && !reset;
    assign rd_data      = rdata_q;
    assign rd_valid     = rvalid_q;
    assign ctl_enable_n = en_n_q;
    assign ctl_cmd      = cmd_q;
    assign ctl_addr     = caddr_q;
    assign ctl_wdata    = wr_data;

endmodule
